// File: rtl/cm_n_sync.sv
// cm_n_sync: clocked N-channel four-phase merge element.
// Arbitrates N upstream Send/Ack channels onto one downstream channel,
// one token at a time. Ack is returned to the granted source only after
// the downstream acknowledges. Also reports collisions and upstream
// protocol violations.
module cm_n_sync #(
  parameter int N        = 2,
  parameter int W        = 8,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 8,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             MR,
  input  logic [N-1:0]     Send_in,
  input  logic [N*W-1:0]   Data_in,
  output logic [N-1:0]     Ack_out,
  output logic             Send_out,
  output logic [W-1:0]     Data_out,
  input  logic             Ack_in,
  output logic [IW-1:0]    grant_idx,
  output logic             busy,
  output logic             aeb,
  output logic [CNT_W-1:0] coll_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RTZ  = 2'd2
  } state_t;

  state_t           r_state, w_state_next;

  logic [N-1:0]     r_ack, w_ack_next;
  logic             r_send, w_send_next;
  logic [W-1:0]     r_data, w_data_next;
  logic [IW-1:0]    r_grant, w_grant_next;
  logic             r_aeb, w_aeb_next;
  logic [CNT_W-1:0] r_coll, w_coll_next;
  logic             r_perr, w_perr_next;
  logic [IW-1:0]    r_ptr, w_ptr_next;

  logic [IW-1:0]    w_sel;
  logic             w_any;
  logic             w_multi;
  logic             w_gnt_send;
  logic [N-1:0]     w_gnt_onehot;
  logic [IW-1:0]    w_ptr_wrap;

  assign w_any      = |Send_in;
  // more than one bit set: clearing the lowest set bit leaves something
  assign w_multi    = |(Send_in & (Send_in - {{(N-1){1'b0}}, 1'b1}));
  assign w_gnt_send = Send_in[r_grant];
  assign w_ptr_wrap = (r_grant == IW'(N - 1)) ? '0 : r_grant + 1'b1;

  // one-hot of the current grant, used to raise the granted Ack bit only
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign w_gnt_onehot[gi] = (r_grant == IW'(gi));
    end
  endgenerate

  // arbiter: round-robin search from the pointer, or lowest index first
  always_comb begin
    w_sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (ARB_MODE == 1) ? k : (int'(r_ptr) + k);
      if (j >= N) j = j - N;
      if (Send_in[j]) w_sel = j[IW-1:0];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (MR) r_state <= S_IDLE;
    else    r_state <= w_state_next;
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any && !Ack_in) w_state_next = S_REQ;
      S_REQ:   if (Ack_in) w_state_next = S_RTZ;
      S_RTZ:   if (!Ack_in && !w_gnt_send) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    w_ack_next   = r_ack;
    w_send_next  = r_send;
    w_data_next  = r_data;
    w_grant_next = r_grant;
    w_aeb_next   = 1'b0;
    w_coll_next  = r_coll;
    w_perr_next  = r_perr;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any && !Ack_in) begin
          w_data_next  = Data_in[w_sel*W +: W];
          w_grant_next = w_sel;
          w_send_next  = 1'b1;
          if (w_multi) begin
            w_aeb_next = 1'b1;
            if (r_coll != {CNT_W{1'b1}}) w_coll_next = r_coll + 1'b1;
          end
        end
      end
      S_REQ: begin
        // source withdrew before being acknowledged; still finish the token
        if (!w_gnt_send) w_perr_next = 1'b1;
        if (Ack_in) begin
          w_send_next = 1'b0;
          w_ack_next  = w_gnt_onehot;
        end
      end
      S_RTZ: begin
        if (!Ack_in && !w_gnt_send) begin
          w_ack_next = '0;
          if (ARB_MODE == 0) w_ptr_next = w_ptr_wrap;
        end
      end
      default: ;
    endcase
  end

  // output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (MR) begin
      r_ack   <= '0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_aeb   <= 1'b0;
      r_coll  <= '0;
      r_perr  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_ack   <= w_ack_next;
      r_send  <= w_send_next;
      r_data  <= w_data_next;
      r_grant <= w_grant_next;
      r_aeb   <= w_aeb_next;
      r_coll  <= w_coll_next;
      r_perr  <= w_perr_next;
      r_ptr   <= w_ptr_next;
    end
  end

  assign Ack_out   = r_ack;
  assign Send_out  = r_send;
  assign Data_out  = r_data;
  assign grant_idx = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign aeb       = r_aeb;
  assign coll_cnt  = r_coll;
  assign proto_err = r_perr;

endmodule

// File: tb/tb_cm_n_sync.sv
// Directed bench for cm_n_sync: a per-cycle vector table on a 2-channel
// round-robin instance, plus hand sequences on a 4-channel fixed-priority
// instance and a 2-channel instance with a 2-bit collision counter.
module tb_cm_n_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: N=2, round-robin, 8-bit counter
  logic        a_mr, a_ack_in, a_sout, a_busy, a_aeb, a_perr;
  logic [1:0]  a_send, a_aout;
  logic [15:0] a_data;
  logic [7:0]  a_dout, a_coll;
  logic        a_g;

  cm_n_sync #(.N(2), .W(8), .ARB_MODE(0), .CNT_W(8)) u_a (
    .clk(clk), .MR(a_mr), .Send_in(a_send), .Data_in(a_data),
    .Ack_out(a_aout), .Send_out(a_sout), .Data_out(a_dout), .Ack_in(a_ack_in),
    .grant_idx(a_g), .busy(a_busy), .aeb(a_aeb), .coll_cnt(a_coll),
    .proto_err(a_perr)
  );

  // instance B: N=4, fixed priority
  logic        b_mr, b_ack_in, b_sout, b_busy, b_aeb, b_perr;
  logic [3:0]  b_send, b_aout;
  logic [31:0] b_data;
  logic [7:0]  b_dout, b_coll;
  logic [1:0]  b_g;

  cm_n_sync #(.N(4), .W(8), .ARB_MODE(1), .CNT_W(8)) u_b (
    .clk(clk), .MR(b_mr), .Send_in(b_send), .Data_in(b_data),
    .Ack_out(b_aout), .Send_out(b_sout), .Data_out(b_dout), .Ack_in(b_ack_in),
    .grant_idx(b_g), .busy(b_busy), .aeb(b_aeb), .coll_cnt(b_coll),
    .proto_err(b_perr)
  );

  // instance C: N=2, round-robin, 2-bit counter
  logic        c_mr, c_ack_in, c_sout, c_busy, c_aeb, c_perr;
  logic [1:0]  c_send, c_aout;
  logic [15:0] c_data;
  logic [7:0]  c_dout;
  logic [1:0]  c_coll;
  logic        c_g;

  cm_n_sync #(.N(2), .W(8), .ARB_MODE(0), .CNT_W(2)) u_c (
    .clk(clk), .MR(c_mr), .Send_in(c_send), .Data_in(c_data),
    .Ack_out(c_aout), .Send_out(c_sout), .Data_out(c_dout), .Ack_in(c_ack_in),
    .grant_idx(c_g), .busy(c_busy), .aeb(c_aeb), .coll_cnt(c_coll),
    .proto_err(c_perr)
  );

  typedef struct {
    logic        mr;
    logic [1:0]  send;
    logic [15:0] data;
    logic        ack;
    logic        sout;
    logic [7:0]  dout;
    logic [1:0]  aout;
    logic        g;
    logic        busy;
    logic        aeb;
    logic [7:0]  coll;
    logic        perr;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic mr, input logic [1:0] send, input logic [15:0] data,
                     input logic ack, input logic sout, input logic [7:0] dout,
                     input logic [1:0] aout, input logic g, input logic busy,
                     input logic aeb, input logic [7:0] coll, input logic perr);
    vecs[nv] = '{mr, send, data, ack, sout, dout, aout, g, busy, aeb, coll, perr};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    a_mr = 1; a_send = 0; a_data = 0; a_ack_in = 0;
    b_mr = 1; b_send = 0; b_data = 0; b_ack_in = 0;
    c_mr = 1; c_send = 0; c_data = 0; c_ack_in = 0;

    //   mr send  data      ack | sout dout   aout g busy aeb coll perr
    // reset with noisy inputs
    add(1, 2'b11, 16'h3C5A, 1,   0, 8'h00, 2'b00, 0, 0, 0, 8'd0, 0);
    add(1, 2'b11, 16'h3C5A, 1,   0, 8'h00, 2'b00, 0, 0, 0, 8'd0, 0);
    // single token on channel 1
    add(0, 2'b10, 16'hA500, 0,   1, 8'hA5, 2'b00, 1, 1, 0, 8'd0, 0);
    add(0, 2'b10, 16'hA500, 1,   0, 8'hA5, 2'b10, 1, 1, 0, 8'd0, 0);
    add(0, 2'b00, 16'hA500, 0,   0, 8'hA5, 2'b00, 1, 0, 0, 8'd0, 0);
    // round-robin: both channels held, four transactions
    add(0, 2'b11, 16'h2211, 0,   1, 8'h11, 2'b00, 0, 1, 1, 8'd1, 0);
    add(0, 2'b11, 16'h2211, 1,   0, 8'h11, 2'b01, 0, 1, 0, 8'd1, 0);
    add(0, 2'b10, 16'h2211, 0,   0, 8'h11, 2'b00, 0, 0, 0, 8'd1, 0);
    add(0, 2'b11, 16'h2211, 0,   1, 8'h22, 2'b00, 1, 1, 1, 8'd2, 0);
    add(0, 2'b11, 16'h2211, 1,   0, 8'h22, 2'b10, 1, 1, 0, 8'd2, 0);
    add(0, 2'b01, 16'h2211, 0,   0, 8'h22, 2'b00, 1, 0, 0, 8'd2, 0);
    add(0, 2'b11, 16'h2211, 0,   1, 8'h11, 2'b00, 0, 1, 1, 8'd3, 0);
    add(0, 2'b11, 16'h2211, 1,   0, 8'h11, 2'b01, 0, 1, 0, 8'd3, 0);
    add(0, 2'b10, 16'h2211, 0,   0, 8'h11, 2'b00, 0, 0, 0, 8'd3, 0);
    add(0, 2'b11, 16'h2211, 0,   1, 8'h22, 2'b00, 1, 1, 1, 8'd4, 0);
    add(0, 2'b11, 16'h2211, 1,   0, 8'h22, 2'b10, 1, 1, 0, 8'd4, 0);
    add(0, 2'b00, 16'h2211, 0,   0, 8'h22, 2'b00, 1, 0, 0, 8'd4, 0);
    // downstream Ack still high in IDLE: no grant
    add(0, 2'b01, 16'h2211, 1,   0, 8'h22, 2'b00, 1, 0, 0, 8'd4, 0);
    add(0, 2'b01, 16'h2211, 0,   1, 8'h11, 2'b00, 0, 1, 0, 8'd4, 0);
    // RTZ waits for the source to drop Send
    add(0, 2'b01, 16'h2211, 1,   0, 8'h11, 2'b01, 0, 1, 0, 8'd4, 0);
    add(0, 2'b01, 16'h2211, 0,   0, 8'h11, 2'b01, 0, 1, 0, 8'd4, 0);
    add(0, 2'b00, 16'h2211, 0,   0, 8'h11, 2'b00, 0, 0, 0, 8'd4, 0);
    // reset while in RTZ with Ack_out[1] high
    add(0, 2'b10, 16'h2211, 0,   1, 8'h22, 2'b00, 1, 1, 0, 8'd4, 0);
    add(0, 2'b10, 16'h2211, 1,   0, 8'h22, 2'b10, 1, 1, 0, 8'd4, 0);
    add(1, 2'b10, 16'h2211, 1,   0, 8'h00, 2'b00, 0, 0, 0, 8'd0, 0);
    add(0, 2'b11, 16'h2211, 0,   1, 8'h11, 2'b00, 0, 1, 1, 8'd1, 0);
    add(0, 2'b11, 16'h2211, 1,   0, 8'h11, 2'b01, 0, 1, 0, 8'd1, 0);
    add(0, 2'b00, 16'h2211, 0,   0, 8'h11, 2'b00, 0, 0, 0, 8'd1, 0);
    // source withdraws in REQ: sticky error, transaction completes
    add(0, 2'b01, 16'h2211, 0,   1, 8'h11, 2'b00, 0, 1, 0, 8'd1, 0);
    add(0, 2'b00, 16'h2211, 0,   1, 8'h11, 2'b00, 0, 1, 0, 8'd1, 1);
    add(0, 2'b00, 16'h2211, 1,   0, 8'h11, 2'b01, 0, 1, 0, 8'd1, 1);
    add(0, 2'b00, 16'h2211, 0,   0, 8'h11, 2'b00, 0, 0, 0, 8'd1, 1);
    add(0, 2'b10, 16'h2211, 0,   1, 8'h22, 2'b00, 1, 1, 0, 8'd1, 1);
    add(0, 2'b10, 16'h2211, 1,   0, 8'h22, 2'b10, 1, 1, 0, 8'd1, 1);
    add(0, 2'b00, 16'h2211, 0,   0, 8'h22, 2'b00, 1, 0, 0, 8'd1, 1);
    add(1, 2'b00, 16'h2211, 0,   0, 8'h00, 2'b00, 0, 0, 0, 8'd0, 0);

    for (int i = 0; i < nv; i++) begin
      logic [22:0] act, exp;
      a_mr = vecs[i].mr; a_send = vecs[i].send; a_data = vecs[i].data; a_ack_in = vecs[i].ack;
      tick();
      act = {a_sout, a_dout, a_aout, a_g, a_busy, a_aeb, a_coll, a_perr};
      exp = {vecs[i].sout, vecs[i].dout, vecs[i].aout, vecs[i].g, vecs[i].busy,
             vecs[i].aeb, vecs[i].coll, vecs[i].perr};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got so=%b do=%h ao=%b g=%0d busy=%b aeb=%b cnt=%0d pe=%b, expected so=%b do=%h ao=%b g=%0d busy=%b aeb=%b cnt=%0d pe=%b",
                 i, a_sout, a_dout, a_aout, a_g, a_busy, a_aeb, a_coll, a_perr,
                 vecs[i].sout, vecs[i].dout, vecs[i].aout, vecs[i].g, vecs[i].busy,
                 vecs[i].aeb, vecs[i].coll, vecs[i].perr);
      end else begin
        $display("[TB] vec%0d ok: so=%b do=%h ao=%b g=%0d cnt=%0d pe=%b",
                 i, a_sout, a_dout, a_aout, a_g, a_coll, a_perr);
      end
    end

    // fixed priority: channels 1 and 3 held, channel 1 always wins
    b_mr = 1; tick(); tick();
    b_mr = 0;
    check("b_reset", {b_sout, b_aout, b_g, b_busy, b_coll}, 32'h0);
    b_data = 32'hDD00_BB00;
    for (int t = 0; t < 3; t++) begin
      b_send = 4'b1010; b_ack_in = 0; tick();
      check("b_grant", {b_sout, b_g, b_dout, b_aeb}, {1'b1, 2'd1, 8'hBB, 1'b1});
      b_ack_in = 1; tick();
      check("b_ack", {b_sout, b_aout}, {1'b0, 4'b0010});
      b_send = 4'b1000; b_ack_in = 0; tick();
      check("b_rtz", {b_busy, b_aout}, {1'b0, 4'b0000});
      $display("[TB] B txn %0d: grant=%0d data=%h cnt=%0d", t, b_g, b_dout, b_coll);
    end
    tick();
    check("b_grant3", {b_sout, b_g, b_dout, b_aeb, b_coll}, {1'b1, 2'd3, 8'hDD, 1'b0, 8'd3});
    b_ack_in = 1; tick();
    check("b_ack3", b_aout, 4'b1000);
    b_send = 0; b_ack_in = 0; tick();
    check("b_idle", {b_busy, b_aout, b_g}, {1'b0, 4'b0000, 2'd3});

    // saturating 2-bit counter, then sticky protocol error
    c_mr = 1; tick(); tick();
    c_mr = 0; c_data = 16'h2211;
    for (int t = 0; t < 5; t++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (t >= 2) ? 2'd3 : 2'(t + 1);
      c_send = 2'b11; c_ack_in = 0; tick();
      check("c_coll", {c_aeb, c_coll, c_g}, {1'b1, exp_cnt, t[0]});
      c_ack_in = 1; tick();
      c_send = (t[0]) ? 2'b01 : 2'b10; c_ack_in = 0; tick();
      $display("[TB] C txn %0d: grant=%0d cnt=%0d", t, c_g, c_coll);
    end
    check("c_perr0", c_perr, 1'b0);
    c_send = 2'b01; c_ack_in = 0; tick();       // single request, ptr at 1 -> ch0
    check("c_single", {c_sout, c_g, c_aeb, c_coll}, {1'b1, 1'b0, 1'b0, 2'd3});
    c_send = 2'b00; tick();
    check("c_perr1", {c_perr, c_sout, c_busy}, {1'b1, 1'b1, 1'b1});
    c_ack_in = 1; tick();
    check("c_perr_ack", {c_aout, c_sout}, {2'b01, 1'b0});
    c_ack_in = 0; tick();
    check("c_perr_done", {c_perr, c_busy, c_aout}, {1'b1, 1'b0, 2'b00});
    tick(); tick();
    check("c_perr_sticky", c_perr, 1'b1);
    c_mr = 1; tick();
    check("c_perr_clr", {c_perr, c_coll}, 32'h0);
    c_mr = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
